unsigned_div_arbiter: RTL and testbench
=======================================

UNSIGNED_DIV_ARBITER -- requirements
Module: unsigned_div_arbiter

Interface
REQ-001 Parameter: Width, default 4, operand/result width in bits (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has a division pending.
REQ-005 req0_a  input  Width  requester 0 dividend.
REQ-006 req0_b  input  Width  requester 0 divisor.
REQ-007 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_ready shall match REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  1  requester index owning the result.
REQ-011 rsp_q  output  Width  quotient.
REQ-012 rsp_r  output  Width  remainder.
REQ-013 rsp_err  output  1  divide-by-zero flag.
REQ-014 rsp_ready  input  1  consumer accepts result.

Function
REQ-015 FSM states: IDLE, CALC, DONE; only IDLE accepts requests.
REQ-016 In IDLE, exactly one reqN_ready is high, for the granted valid requester; both are low when neither is valid and in CALC/DONE.
REQ-017 Arbitration: single valid request wins; both valid -> grant the requester not granted last; last-grant pointer resets to 1 so requester 0 wins the first tie.
REQ-018 Acceptance at cycle T (valid & ready) latches a, b, id and updates the last-grant pointer.
REQ-019 b != 0: IDLE -> CALC; Width CALC cycles, one quotient bit per cycle, MSB first; rsp_valid rises at T+Width+1.
REQ-020 CALC step: partial remainder (Width+1 bits) = {rem, next dividend bit}; if >= b, subtract b and set quotient bit to 1, else quotient bit 0.
REQ-021 Final rsp_q = a / b, rsp_r = a % b, rsp_err = 0, for all operand values including a < b and b = 1.
REQ-022 b == 0: IDLE -> DONE directly; rsp_valid rises at T+1 with rsp_q = 0, rsp_r = 0, rsp_err = 1.
REQ-023 In DONE, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err are held stable until rsp_ready is high.
REQ-024 DONE & rsp_ready -> IDLE; no request is accepted in that same cycle (one-cycle bubble).
REQ-025 rsp_valid is low in IDLE and CALC; rsp_ready is ignored outside DONE.
REQ-026 A requester dropping valid after acceptance has no effect on the operation in flight.

Reset
REQ-027 rst_n low shall immediately force state IDLE, rsp_valid 0, rsp_id 0, rsp_q 0, rsp_r 0, rsp_err 0, req0_ready 0, req1_ready 0, last-grant pointer 1.
REQ-028 Reset during CALC or DONE shall discard the operation in flight; no response is ever produced for it.
REQ-029 After rst_n deasserts, the first acceptance shall occur no earlier than the first rising edge with rst_n high.

Structure
REQ-030 Shared package div_pkg shall hold the FSM state encoding (IDLE, CALC, DONE) and the requester-count constant (2).
REQ-031 The iterative shift/subtract datapath shall be sub-module div_seq_core (start, a, b -> busy, done, q, r), one bit per cycle; arbitration, FSM and response registers stay in unsigned_div_arbiter.
REQ-032 No combinational path from rsp_ready to reqN_ready.

Verification
REQ-033 Width=4, req0 a=13 b=3 accepted at T -> rsp_valid at T+5, rsp_id=0, q=4, r=1, err=0.
REQ-034 req1 a=7 b=0 -> rsp_valid at T+1, rsp_id=1, q=0, r=0, err=1.
REQ-035 Both valid continuously after reset (req0 15/1, req1 3/7) -> grants alternate 0,1,0,...; responses 15 r0 and 0 r3.
REQ-036 rsp_ready held low 10 cycles after rsp_valid -> outputs stable, both reqN_ready low; rsp_ready high -> IDLE next cycle, next acceptance one cycle later.
REQ-037 rst_n low at T+2 of a 9/2 operation -> outputs zero immediately, no response after release; new 9/2 -> q=4, r=1.
REQ-038 Exhaustive sweep a,b in 0..15 from alternating requesters -> every result matches a/b, a%b, or err for b=0.

Source files
------------

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the two-requester unsigned divider:
//   state_t  - control FSM encoding (IDLE accepts, CALC iterates, DONE holds)
//   NUM_REQ  - number of requesters sharing the divider
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/unsigned_div_arbiter_if.sv
// -----------------------------------------------------------------------------
// unsigned_div_arbiter_if
// Bundles the two request channels and the response channel of the shared
// divider.
//   reqN_valid/reqN_a/reqN_b  requester N operands, reqN_ready = accepted
//   rsp_valid/rsp_id/rsp_q/rsp_r/rsp_err  result, rsp_ready = consumed
// Modports:
//   slave  - the divider (consumes requests, produces responses)
//   master - the requesters/consumer side
// -----------------------------------------------------------------------------
interface unsigned_div_arbiter_if #(
    parameter int Width = 4
);
    logic             req0_valid;
    logic [Width-1:0] req0_a;
    logic [Width-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [Width-1:0] req1_a;
    logic [Width-1:0] req1_b;
    logic             req1_ready;

    logic             rsp_valid;
    logic             rsp_id;
    logic [Width-1:0] rsp_q;
    logic [Width-1:0] rsp_r;
    logic             rsp_err;
    logic             rsp_ready;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err
    );

endinterface

// File: rtl/div_seq_core.sv
// -----------------------------------------------------------------------------
// div_seq_core
// Restoring shift/subtract divider, one quotient bit per cycle, MSB first.
// The first bit is resolved on the start edge directly from the a/b inputs,
// so a full result takes Width edges and done pulses for one cycle in the
// cycle after the last step, with q/r already valid.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       begin a division with a/b (b must be non-zero)
//   a, b        dividend, divisor
//   busy        iterations still outstanding
//   done        one-cycle pulse, q/r hold the final result
//   q, r        quotient, remainder
// -----------------------------------------------------------------------------
module div_seq_core #(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] q,
    output logic [Width-1:0] r
);
    localparam int CntW = $clog2(Width) + 1;

    // acc_q starts as the dividend; each step shifts its MSB into the
    // partial remainder and the new quotient bit into its LSB.
    logic [Width-1:0] rem_q, acc_q, div_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q, done_q;

    logic [Width-1:0] src_rem, src_acc, src_div;
    logic [Width:0]   partial;
    logic [Width-1:0] rem_next, acc_next;
    logic             q_bit;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no
        // latches are inferred.
        src_rem  = start ? '0 : rem_q;
        src_acc  = start ? a  : acc_q;
        src_div  = start ? b  : div_q;
        partial  = {src_rem, src_acc[Width-1]};
        q_bit    = 1'b0;
        rem_next = partial[Width-1:0];
        if (partial >= {1'b0, src_div}) begin
            q_bit    = 1'b1;
            rem_next = Width'(partial - {1'b0, src_div});
        end
        acc_next = {src_acc[Width-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is written only with non-blocking
            // assignments so all registers update from pre-edge values.
            rem_q  <= '0;
            acc_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                div_q  <= b;
                rem_q  <= rem_next;
                acc_q  <= acc_next;
                cnt_q  <= CntW'(Width - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_next;
                acc_q <= acc_next;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = acc_q;
    assign r    = rem_q;

endmodule

// File: rtl/unsigned_div_arbiter.sv
// -----------------------------------------------------------------------------
// unsigned_div_arbiter
// Shares one sequential divider between two requesters. Round-robin grant on
// ties (requester 0 wins the first), divide-by-zero answered in one cycle
// with rsp_err, otherwise the result appears Width+1 cycles after acceptance
// and is held until the consumer takes it.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         unsigned_div_arbiter_if.slave (requests in, response out)
// -----------------------------------------------------------------------------
module unsigned_div_arbiter
    import div_pkg::*;
#(
    parameter int Width = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    unsigned_div_arbiter_if.slave  bus
);
    localparam int IdW = $clog2(NUM_REQ);

    state_t           state_q, state_d;
    logic [IdW-1:0]   last_grant_q;
    logic [IdW-1:0]   grant;
    logic             accept;
    logic             ready0, ready1;
    logic             core_start;
    logic [Width-1:0] sel_a, sel_b;

    logic             core_busy, core_done;
    logic [Width-1:0] core_q, core_r;

    logic [IdW-1:0]   rsp_id_q;
    logic [Width-1:0] rsp_q_q, rsp_r_q;
    logic             rsp_err_q;

    // Arbitration. The ready path depends only on registered state and the
    // request valids, never on rsp_ready; the DONE->IDLE edge provides the
    // bubble. Readies are held low while rst_n is asserted.
    always_comb begin
        grant = '0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant = IdW'(1);
        end
        accept = rst_n && (state_q == IDLE) && !core_busy &&
                 (bus.req0_valid || bus.req1_valid);
        sel_a  = (grant == '0) ? bus.req0_a : bus.req1_a;
        sel_b  = (grant == '0) ? bus.req0_b : bus.req1_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ready0     = 1'b0;
        ready1     = 1'b0;
        core_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ready0 = (grant == '0);
                    ready1 = (grant != '0);
                    if (sel_b == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = CALC;
                        core_start = 1'b1;
                    end
                end
            end
            CALC: begin
                if (core_done) state_d = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response registers: id at acceptance, data either immediately (b == 0)
    // or when the core finishes. Nothing changes while in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IdW'(1);
            rsp_id_q     <= '0;
            rsp_q_q      <= '0;
            rsp_r_q      <= '0;
            rsp_err_q    <= 1'b0;
        end else if (accept) begin
            last_grant_q <= grant;
            rsp_id_q     <= grant;
            if (sel_b == '0) begin
                rsp_q_q   <= '0;
                rsp_r_q   <= '0;
                rsp_err_q <= 1'b1;
            end
        end else if ((state_q == CALC) && core_done) begin
            rsp_q_q   <= core_q;
            rsp_r_q   <= core_r;
            rsp_err_q <= 1'b0;
        end
    end

    div_seq_core #(.Width(Width)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .a     (sel_a),
        .b     (sel_b),
        .busy  (core_busy),
        .done  (core_done),
        .q     (core_q),
        .r     (core_r)
    );

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_q      = rsp_q_q;
    assign bus.rsp_r      = rsp_r_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_unsigned_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unsigned_div_arbiter
// Drives the shared divider with directed and random operations and checks
// grants, latency, results and hold behaviour against a plain arithmetic
// model (a / b, a % b, round-robin pointer).
// -----------------------------------------------------------------------------
module tb_unsigned_div_arbiter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   last_grant = 1;

    unsigned_div_arbiter_if #(.Width(W)) bus ();

    unsigned_div_arbiter #(.Width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready0"}, int'(bus.req0_ready), 0);
        check({tag, "_ready1"}, int'(bus.req1_ready), 0);
    endtask

    task automatic check_rsp(input string tag, input int id, input int a, input int b);
        check({tag, "_valid"}, int'(bus.rsp_valid), 1);
        check({tag, "_id"},    int'(bus.rsp_id), id);
        check({tag, "_q"},     int'(bus.rsp_q), (b == 0) ? 0 : a / b);
        check({tag, "_r"},     int'(bus.rsp_r), (b == 0) ? 0 : a % b);
        check({tag, "_err"},   int'(bus.rsp_err), (b == 0) ? 1 : 0);
    endtask

    task automatic rand_inputs(input bit with_ready);
        bus.req0_valid = 1'($urandom_range(0, 1));
        bus.req1_valid = 1'($urandom_range(0, 1));
        bus.req0_a     = W'($urandom_range(0, 15));
        bus.req0_b     = W'($urandom_range(0, 15));
        bus.req1_a     = W'($urandom_range(0, 15));
        bus.req1_b     = W'($urandom_range(0, 15));
        if (with_ready) bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    // One complete transaction, starting in an IDLE cycle just after a
    // negedge. scramble disturbs requests (and rsp_ready before the result)
    // while the operation is in flight.
    task automatic do_op(input bit v0, input int a0, input int b0,
                         input bit v1, input int a1, input int b1,
                         input int hold, input bit scramble);
        int  g, ea, eb, t0;
        bit  seen;
        g  = (v0 && v1) ? (1 - last_grant) : (v0 ? 0 : 1);
        ea = (g == 0) ? a0 : a1;
        eb = (g == 0) ? b0 : b1;
        bus.req0_valid = v0;
        bus.req0_a     = W'(a0);
        bus.req0_b     = W'(b0);
        bus.req1_valid = v1;
        bus.req1_a     = W'(a1);
        bus.req1_b     = W'(b1);
        bus.rsp_ready  = 1'b0;
        #1;
        check("grant0", int'(bus.req0_ready), (g == 0) ? 1 : 0);
        check("grant1", int'(bus.req1_ready), (g == 1) ? 1 : 0);
        last_grant = g;
        t0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < W + 4 && !seen; i++) begin
            @(negedge clk);
            if (scramble) rand_inputs(1'b1);
            #1;
            if (bus.rsp_valid) seen = 1'b1;
            else check_quiet("busy");
        end
        bus.rsp_ready = 1'b0;
        check("rsp_seen", int'(seen), 1);
        if (!seen) return;
        check("latency", cyc - t0, (eb == 0) ? 1 : W + 1);
        check_rsp("rsp", g, ea, eb);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (scramble) rand_inputs(1'b0);
            #1;
            check_rsp("hold", g, ea, eb);
            check_quiet("hold");
        end
        // Consume with both requesters pending: no grant may appear until
        // the cycle after the handshake.
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b1;
        #1;
        check_quiet("bubble");
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        check("idle_valid", int'(bus.rsp_valid), 0);
    endtask

    initial begin
        bus.req0_valid = 1'b1;
        bus.req0_a     = W'(15);
        bus.req0_b     = W'(1);
        bus.req1_valid = 1'b1;
        bus.req1_a     = W'(3);
        bus.req1_b     = W'(7);
        bus.rsp_ready  = 1'b1;

        // Reset state with requests already pending.
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        check("reset_valid", int'(bus.rsp_valid), 0);
        check("reset_id",    int'(bus.rsp_id), 0);
        check("reset_q",     int'(bus.rsp_q), 0);
        check("reset_r",     int'(bus.rsp_r), 0);
        check("reset_err",   int'(bus.rsp_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous contention: grants alternate starting with requester 0.
        for (int i = 0; i < 4; i++) do_op(1, 15, 1, 1, 3, 7, 0, 0);

        // Directed cases.
        do_op(1, 13, 3, 0, 0, 0, 0, 0);
        do_op(0, 0, 0, 1, 7, 0, 0, 0);
        do_op(0, 0, 0, 1, 14, 3, 10, 0);

        // Reset in the middle of a calculation.
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_a     = W'(9);
        bus.req1_b     = W'(2);
        #1;
        check("abort_grant", int'(bus.req1_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        check("abort_valid", int'(bus.rsp_valid), 0);
        check("abort_id",    int'(bus.rsp_id), 0);
        check("abort_q",     int'(bus.rsp_q), 0);
        check("abort_r",     int'(bus.rsp_r), 0);
        check("abort_err",   int'(bus.rsp_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        last_grant = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("abort_silent", int'(bus.rsp_valid), 0);
        end
        do_op(1, 9, 2, 0, 0, 0, 0, 0);

        // Random traffic with in-flight disturbance and random hold.
        for (int i = 0; i < 150; i++) begin
            bit v0, v1;
            int a0, b0, a1, b1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            a0 = $urandom_range(0, 15);
            a1 = $urandom_range(0, 15);
            b0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
            b1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
            do_op(v0, a0, b0, v1, a1, b1, $urandom_range(0, 3), 1);
        end

        // Exhaustive operand sweep from alternating requesters.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                bit id;
                id = 1'((a * 16 + b) & 1);
                do_op(!id, a, b, id, a, b, 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
